// File: rtl/stopwatch_digit_chain.sv
// Cascaded up/down digit counter for the stopwatch datapath.
// Digits alternate between EVEN_MOD and ODD_MOD; the default setup counts mm:ss.
module stopwatch_digit_chain #(
    parameter int NUM_DIGITS = 4,
    parameter int EVEN_MOD   = 10,
    parameter int ODD_MOD    = 6,
    parameter int SATURATE   = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      up_dn,
    input  logic                      clear,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   load_val,
    output logic [4*NUM_DIGITS-1:0]   count,
    output logic                      wrap,
    output logic                      at_term
);

    logic [4*NUM_DIGITS-1:0] count_q, count_d;
    logic                    wrap_q, wrap_d;
    logic [NUM_DIGITS:0]     step;
    logic                    term;

    function automatic logic [3:0] digit_max(input int unsigned idx);
        return (idx % 2 == 0) ? 4'(EVEN_MOD - 1) : 4'(ODD_MOD - 1);
    endfunction

    // step[i] is set when every digit below i sits at its terminal value for
    // the current direction; step[NUM_DIGITS] therefore means the whole chain is terminal.
    always_comb begin
        step    = '0;
        step[0] = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            step[i+1] = step[i] && (up_dn ? (count_q[4*i +: 4] == digit_max(i))
                                          : (count_q[4*i +: 4] == 4'd0));
        end
    end

    assign term = step[NUM_DIGITS];

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                count_d[4*i +: 4] = (load_val[4*i +: 4] > digit_max(i)) ? digit_max(i)
                                                                         : load_val[4*i +: 4];
            end
        end else if (en && !(term && (SATURATE != 0))) begin
            wrap_d = term;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (step[i]) begin
                    if (up_dn)
                        count_d[4*i +: 4] = (count_q[4*i +: 4] == digit_max(i)) ? 4'd0
                                                                                 : count_q[4*i +: 4] + 4'd1;
                    else
                        count_d[4*i +: 4] = (count_q[4*i +: 4] == 4'd0) ? digit_max(i)
                                                                        : count_q[4*i +: 4] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count   = count_q;
    assign wrap    = wrap_q;
    assign at_term = term;

endmodule
